// File: rtl/wired0_pkg.sv
// Shared TLB management types: request op codes, the stored key layout,
// INVTLB op codes and the invalidation predicate.
package wired0_pkg;

  typedef enum logic [2:0] {
    OP_SRCH = 3'd0,
    OP_RD   = 3'd1,
    OP_WR   = 3'd2,
    OP_FILL = 3'd3,
    OP_INV  = 3'd4
  } tlb_op_t;

  typedef struct packed {
    logic        e;
    logic        g;
    logic        huge_page;
    logic [9:0]  asid;
    logic [18:0] vppn;
  } tlb_key_t;

  localparam logic [4:0] INV_ALL0       = 5'd0;
  localparam logic [4:0] INV_ALL1       = 5'd1;
  localparam logic [4:0] INV_G1         = 5'd2;
  localparam logic [4:0] INV_G0         = 5'd3;
  localparam logic [4:0] INV_G0_ASID    = 5'd4;
  localparam logic [4:0] INV_G0_ASID_VA = 5'd5;
  localparam logic [4:0] INV_GA_VA      = 5'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRCH,
    ST_UPD,
    ST_INV,
    ST_RSP
  } mgr_state_t;

  // True when a valid entry is selected by an INVTLB op; a huge page compares
  // only the vppn bits above its 1024-page span.
  function automatic logic inv_hit(input logic [4:0]  op,
                                   input tlb_key_t    key,
                                   input logic [9:0]  asid,
                                   input logic [18:0] vppn);
    logic asid_eq;
    logic vppn_eq;
    logic sel;
    asid_eq = (key.asid == asid);
    vppn_eq = key.huge_page ? (key.vppn[18:10] == vppn[18:10]) : (key.vppn == vppn);
    case (op)
      INV_ALL0, INV_ALL1: sel = 1'b1;
      INV_G1:             sel = key.g;
      INV_G0:             sel = !key.g;
      INV_G0_ASID:        sel = !key.g && asid_eq;
      INV_G0_ASID_VA:     sel = !key.g && asid_eq && vppn_eq;
      INV_GA_VA:          sel = (key.g || asid_eq) && vppn_eq;
      default:            sel = 1'b0;
    endcase
    return key.e && sel;
  endfunction

endpackage

// File: rtl/wired_tlb_prio_enc.sv
// Lowest-index priority encoder over the per-entry match vector.
module wired_tlb_prio_enc #(
  parameter  int N  = 32,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o
);

  // NOTE: combinational blocks give every output a default before any branch,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IW'(i);
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/wired_tlb_mgr.sv
// TLB management controller: sequences search, read, write, fill and INVTLB
// scans against an external key store and per-entry matchers.
module wired_tlb_mgr
  import wired0_pkg::*;
#(
  parameter  int TLB_ENTRIES = 32,
  localparam int IDXW        = $clog2(TLB_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  tlb_op_t                req_op_i,
  input  logic [IDXW-1:0]        req_idx_i,
  input  tlb_key_t               req_key_i,
  input  logic [4:0]             inv_op_i,
  input  logic [9:0]             inv_asid_i,
  input  logic [18:0]            inv_vppn_i,
  output logic [18:0]            lkp_vppn_o,
  output logic [9:0]             lkp_asid_o,
  input  logic [TLB_ENTRIES-1:0] match_i,
  output logic [IDXW-1:0]        rd_idx_o,
  input  tlb_key_t               rd_key_i,
  output logic [TLB_ENTRIES-1:0] upd_o,
  output tlb_key_t               upd_key_o,
  output logic                   rsp_valid_o,
  output logic                   rsp_hit_o,
  output logic [IDXW-1:0]        rsp_idx_o,
  output tlb_key_t               rsp_key_o,
  output logic                   rsp_err_o
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TLB_ENTRIES - 1);

  mgr_state_t      r_state;
  mgr_state_t      w_next;
  tlb_op_t         r_op;
  logic [IDXW-1:0] r_idx;
  logic [IDXW-1:0] r_fill_cnt;
  logic [IDXW-1:0] r_rd_idx;
  logic [IDXW-1:0] r_rsp_idx;
  tlb_key_t        r_key;
  tlb_key_t        r_rsp_key;
  tlb_key_t        w_scan_key;
  logic [4:0]      r_inv_op;
  logic [9:0]      r_inv_asid;
  logic [18:0]     r_inv_vppn;
  logic [9:0]      r_lkp_asid;
  logic [18:0]     r_lkp_vppn;
  logic            r_inv_arm;
  logic            r_rsp_hit;
  logic            r_rsp_err;
  logic            w_inv_illegal;
  logic            w_any;
  logic [IDXW-1:0] w_enc_idx;

  wired_tlb_prio_enc #(.N(TLB_ENTRIES)) u_prio_enc (
    .vec_i (match_i),
    .any_o (w_any),
    .idx_o (w_enc_idx)
  );

  assign w_inv_illegal = (r_inv_op > INV_GA_VA);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    upd_o      = '0;
    upd_key_o  = '0;
    w_scan_key = rd_key_i;
    w_scan_key.e = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid_i) begin
          case (req_op_i)
            OP_SRCH, OP_RD:  w_next = ST_SRCH;
            OP_WR, OP_FILL:  w_next = ST_UPD;
            OP_INV:          w_next = ST_INV;
            default:         w_next = ST_RSP;
          endcase
        end
      end
      ST_SRCH: w_next = ST_RSP;
      ST_UPD: begin
        w_next       = ST_RSP;
        upd_o[r_idx] = 1'b1;
        upd_key_o    = r_key;
      end
      ST_INV: begin
        // The first INV cycle only qualifies the op code; the scan follows.
        if (r_inv_arm) begin
          if (w_inv_illegal) w_next = ST_RSP;
        end else begin
          if (inv_hit(r_inv_op, rd_key_i, r_inv_asid, r_inv_vppn)) begin
            upd_o[r_rd_idx] = 1'b1;
            upd_key_o       = w_scan_key;
          end
          if (r_rd_idx == LAST_IDX) w_next = ST_RSP;
        end
      end
      ST_RSP:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_cnt <= '0;
      r_op       <= OP_SRCH;
      r_idx      <= '0;
      r_key      <= '0;
      r_rd_idx   <= '0;
      r_inv_op   <= '0;
      r_inv_asid <= '0;
      r_inv_vppn <= '0;
      r_inv_arm  <= 1'b0;
      r_lkp_asid <= '0;
      r_lkp_vppn <= '0;
      r_rsp_hit  <= 1'b0;
      r_rsp_idx  <= '0;
      r_rsp_key  <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_fill_cnt <= r_fill_cnt + IDXW'(1);
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i) begin
            r_op  <= req_op_i;
            r_key <= req_key_i;
            r_idx <= (req_op_i == OP_FILL) ? r_fill_cnt : req_idx_i;
            case (req_op_i)
              OP_SRCH: begin
                r_lkp_vppn <= req_key_i.vppn;
                r_lkp_asid <= req_key_i.asid;
              end
              OP_RD: r_rd_idx <= req_idx_i;
              OP_INV: begin
                r_inv_op   <= inv_op_i;
                r_inv_asid <= inv_asid_i;
                r_inv_vppn <= inv_vppn_i;
                r_inv_arm  <= 1'b1;
                r_rd_idx   <= '0;
              end
              OP_WR, OP_FILL: ;
              default: begin
                r_rsp_hit <= 1'b0;
                r_rsp_err <= 1'b0;
              end
            endcase
          end
        end
        ST_SRCH: begin
          r_rsp_err <= 1'b0;
          if (r_op == OP_RD) begin
            r_rsp_hit <= 1'b0;
            r_rsp_key <= rd_key_i;
          end else begin
            r_rsp_hit <= w_any;
            r_rsp_idx <= w_enc_idx;
          end
        end
        ST_UPD: begin
          r_rsp_hit <= 1'b0;
          r_rsp_err <= 1'b0;
          if (r_op == OP_FILL) r_rsp_idx <= r_idx;
        end
        ST_INV: begin
          if (r_inv_arm) begin
            r_inv_arm <= 1'b0;
            if (w_inv_illegal) begin
              r_rsp_hit <= 1'b0;
              r_rsp_err <= 1'b1;
            end
          end else if (r_rd_idx == LAST_IDX) begin
            r_rsp_hit <= 1'b0;
            r_rsp_err <= 1'b0;
          end else begin
            r_rd_idx <= r_rd_idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o = (r_state == ST_IDLE);
  assign rsp_valid_o = (r_state == ST_RSP);
  assign rsp_hit_o   = r_rsp_hit;
  assign rsp_idx_o   = r_rsp_idx;
  assign rsp_key_o   = r_rsp_key;
  assign rsp_err_o   = r_rsp_err;
  assign rd_idx_o    = r_rd_idx;
  assign lkp_vppn_o  = r_lkp_vppn;
  assign lkp_asid_o  = r_lkp_asid;

endmodule

// File: tb/tb_wired_tlb_mgr.sv
// Bench for wired_tlb_mgr: an environment key store driven by upd_o, a
// reference key array and rule-level expectations for every response.
module tb_wired_tlb_mgr;
  import wired0_pkg::*;

  localparam int N  = 32;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid_i;
  logic          req_ready_o;
  tlb_op_t       req_op_i;
  logic [IW-1:0] req_idx_i;
  tlb_key_t      req_key_i;
  logic [4:0]    inv_op_i;
  logic [9:0]    inv_asid_i;
  logic [18:0]   inv_vppn_i;
  logic [18:0]   lkp_vppn_o;
  logic [9:0]    lkp_asid_o;
  logic [N-1:0]  match_i;
  logic [IW-1:0] rd_idx_o;
  tlb_key_t      rd_key_i;
  logic [N-1:0]  upd_o;
  tlb_key_t      upd_key_o;
  logic          rsp_valid_o;
  logic          rsp_hit_o;
  logic [IW-1:0] rsp_idx_o;
  tlb_key_t      rsp_key_o;
  logic          rsp_err_o;

  int total = 0;
  int bad   = 0;

  tlb_key_t ks     [N];
  tlb_key_t ld_ks  [N];
  tlb_key_t ref_ks [N];
  logic     ld_all = 1'b0;
  int       tb_cnt;

  always #5 clk = ~clk;

  wired_tlb_mgr #(.TLB_ENTRIES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_idx_i(req_idx_i), .req_key_i(req_key_i),
    .inv_op_i(inv_op_i), .inv_asid_i(inv_asid_i), .inv_vppn_i(inv_vppn_i),
    .lkp_vppn_o(lkp_vppn_o), .lkp_asid_o(lkp_asid_o), .match_i(match_i),
    .rd_idx_o(rd_idx_o), .rd_key_i(rd_key_i),
    .upd_o(upd_o), .upd_key_o(upd_key_o),
    .rsp_valid_o(rsp_valid_o), .rsp_hit_o(rsp_hit_o), .rsp_idx_o(rsp_idx_o),
    .rsp_key_o(rsp_key_o), .rsp_err_o(rsp_err_o)
  );

  // Environment key store: combinational read, written by the update strobe.
  assign rd_key_i = ks[rd_idx_o];
  always @(posedge clk) begin
    if (ld_all) begin
      for (int i = 0; i < N; i++) ks[i] <= ld_ks[i];
    end else begin
      for (int i = 0; i < N; i++) if (upd_o[i]) ks[i] <= upd_key_o;
    end
  end

  // Free-running fill counter as the rules describe it: cycles since reset mod N.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= 0;
    else        tb_cnt <= (tb_cnt + 1) % N;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic bit tb_pred(input int op, input tlb_key_t k, input logic [9:0] a, input logic [18:0] v);
    bit am;
    bit vm;
    am = (k.asid == a);
    vm = k.huge_page ? (k.vppn[18:10] == v[18:10]) : (k.vppn == v);
    if (!k.e) return 0;
    if (op == 0 || op == 1) return 1;
    if (op == 2) return k.g;
    if (op == 3) return !k.g;
    if (op == 4) return !k.g && am;
    if (op == 5) return !k.g && am && vm;
    if (op == 6) return (k.g || am) && vm;
    return 0;
  endfunction

  function automatic tlb_key_t rand_key();
    return tlb_key_t'($urandom());
  endfunction

  task automatic load_store();
    for (int i = 0; i < N; i++) ref_ks[i] = ld_ks[i];
    @(negedge clk);
    ld_all = 1'b1;
    @(negedge clk);
    ld_all = 1'b0;
  endtask

  task automatic chk_fields(input string pfx, input tlb_op_t op, input logic eh,
                            input logic [IW-1:0] ei, input tlb_key_t ek, input logic ee);
    case (op)
      OP_SRCH: begin
        check({pfx, "_hit"}, rsp_hit_o, eh);
        check({pfx, "_idx"}, rsp_idx_o, ei);
      end
      OP_RD:   check({pfx, "_key"}, rsp_key_o, ek);
      OP_FILL: check({pfx, "_fill_idx"}, rsp_idx_o, ei);
      OP_INV:  check({pfx, "_err"}, rsp_err_o, ee);
      default: ;
    endcase
  endtask

  // One complete request: expectations from the reference array, then
  // cycle-by-cycle comparison of upd_o and the response.
  task automatic do_req(input tlb_op_t op, input logic [IW-1:0] idx, input tlb_key_t key,
                        input logic [N-1:0] match, input logic [4:0] iop,
                        input logic [9:0] ia, input logic [18:0] iv, output int lat_o);
    logic [N-1:0]  eu [64];
    tlb_key_t      ek [64];
    int            exp_lat;
    logic          e_hit;
    logic [IW-1:0] e_idx;
    tlb_key_t      e_key;
    logic          e_err;
    tlb_key_t      cleared;
    int            fi;
    bit            seen;
    for (int c = 0; c < 64; c++) begin
      eu[c] = '0;
      ek[c] = '0;
    end
    e_hit = 1'b0; e_idx = '0; e_key = '0; e_err = 1'b0; exp_lat = 2; lat_o = 0; seen = 0;
    @(negedge clk);
    case (op)
      OP_SRCH: begin
        e_hit = (match != 0);
        e_idx = IW'(lowest(match));
      end
      OP_RD: e_key = ref_ks[idx];
      OP_WR, OP_FILL: begin
        fi = (op == OP_FILL) ? tb_cnt : int'(idx);
        e_idx = IW'(fi);
        eu[1][fi] = 1'b1;
        ek[1] = key;
        ref_ks[fi] = key;
      end
      OP_INV: begin
        if (iop > 6) begin
          e_err = 1'b1;
        end else begin
          exp_lat = N + 2;
          for (int k = 0; k < N; k++) begin
            if (tb_pred(int'(iop), ref_ks[k], ia, iv)) begin
              cleared   = ref_ks[k];
              cleared.e = 1'b0;
              eu[k + 2][k] = 1'b1;
              ek[k + 2]    = cleared;
              ref_ks[k]    = cleared;
            end
          end
        end
      end
      default: ;
    endcase
    req_valid_i = 1'b1; req_op_i = op; req_idx_i = idx; req_key_i = key;
    inv_op_i = iop; inv_asid_i = ia; inv_vppn_i = iv; match_i = match;
    check("ready_at_accept", req_ready_o, 1'b1);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    for (int c = 1; c < 64 && !seen; c++) begin
      @(negedge clk);
      check($sformatf("upd_c%0d", c), upd_o, eu[c]);
      if (eu[c] != 0) check($sformatf("upd_key_c%0d", c), upd_key_o, ek[c]);
      if (op == OP_SRCH && c == 1) check("lkp", {lkp_asid_o, lkp_vppn_o}, {key.asid, key.vppn});
      if (rsp_valid_o) begin
        seen  = 1;
        lat_o = c;
        chk_fields("rsp", op, e_hit, e_idx, e_key, e_err);
      end
    end
    check("latency", lat_o, exp_lat);
    @(negedge clk);
    check("rsp_pulse", rsp_valid_o, 1'b0);
    check("upd_after", upd_o, '0);
    chk_fields("hold", op, e_hit, e_idx, e_key, e_err);
  endtask

  typedef struct {
    tlb_op_t       op;
    logic [IW-1:0] idx;
    tlb_key_t      key;
    logic [N-1:0]  match;
    logic [4:0]    iop;
    logic [9:0]    ia;
    int            lat;
    bit            chk_hit;
    logic          hit;
    bit            chk_idx;
    logic [IW-1:0] ridx;
    bit            chk_err;
    logic          err;
  } vec_t;

  localparam tlb_key_t KEY_S = '{e:1'b1, g:1'b0, huge_page:1'b0, asid:10'h12,  vppn:19'h01234};
  localparam tlb_key_t KEY_W = '{e:1'b1, g:1'b1, huge_page:1'b0, asid:10'h155, vppn:19'h7abcd};
  localparam tlb_key_t KEY_F = '{e:1'b0, g:1'b0, huge_page:1'b1, asid:10'h0a,  vppn:19'h00c00};

  vec_t tbl [12];

  initial begin
    tlb_op_t       op;
    tlb_key_t      src;
    logic [IW-1:0] ridx;
    logic [N-1:0]  m;
    logic [4:0]    iop;
    logic [9:0]    ia;
    logic [18:0]   iv;
    int            lat;
    int            sel;

    tbl[0]  = '{OP_SRCH, 5'd0, KEY_S, 32'h0000_0050, 5'd0, 10'h0,   2,      1, 1'b1, 1, 5'd4,  0, 1'b0};
    tbl[1]  = '{OP_SRCH, 5'd0, KEY_S, 32'h0000_0000, 5'd0, 10'h0,   2,      1, 1'b0, 1, 5'd0,  0, 1'b0};
    tbl[2]  = '{OP_SRCH, 5'd0, KEY_S, 32'h8000_0000, 5'd0, 10'h0,   2,      1, 1'b1, 1, 5'd31, 0, 1'b0};
    tbl[3]  = '{OP_SRCH, 5'd0, KEY_S, 32'hffff_0006, 5'd0, 10'h0,   2,      1, 1'b1, 1, 5'd1,  0, 1'b0};
    tbl[4]  = '{OP_RD,   5'd1, '0,    32'h0,         5'd0, 10'h0,   2,      0, 1'b0, 0, 5'd0,  0, 1'b0};
    tbl[5]  = '{OP_INV,  5'd0, '0,    32'h0,         5'd4, 10'h12,  N + 2,  0, 1'b0, 0, 5'd0,  1, 1'b0};
    tbl[6]  = '{OP_RD,   5'd0, '0,    32'h0,         5'd0, 10'h0,   2,      0, 1'b0, 0, 5'd0,  0, 1'b0};
    tbl[7]  = '{OP_WR,   5'd7, KEY_W, 32'h0,         5'd0, 10'h0,   2,      0, 1'b0, 0, 5'd0,  0, 1'b0};
    tbl[8]  = '{OP_RD,   5'd7, '0,    32'h0,         5'd0, 10'h0,   2,      0, 1'b0, 0, 5'd0,  0, 1'b0};
    tbl[9]  = '{OP_INV,  5'd0, '0,    32'h0,         5'd9, 10'h0,   2,      0, 1'b0, 0, 5'd0,  1, 1'b1};
    tbl[10] = '{OP_FILL, 5'd0, KEY_F, 32'h0,         5'd0, 10'h0,   2,      0, 1'b0, 0, 5'd0,  0, 1'b0};
    tbl[11] = '{OP_INV,  5'd0, '0,    32'h0,         5'd2, 10'h0,   N + 2,  0, 1'b0, 0, 5'd0,  1, 1'b0};

    rst_n = 1'b0; req_valid_i = 1'b0; req_op_i = OP_SRCH; req_idx_i = '0; req_key_i = '0;
    inv_op_i = '0; inv_asid_i = '0; inv_vppn_i = '0; match_i = '0;

    for (int i = 0; i < N; i++) begin
      ld_ks[i]   = rand_key();
      ld_ks[i].e = 1'b0;
    end
    ld_ks[0] = '{e:1'b1, g:1'b0, huge_page:1'b0, asid:10'h12, vppn:19'h00100};
    ld_ks[1] = '{e:1'b1, g:1'b1, huge_page:1'b0, asid:10'h12, vppn:19'h00200};
    ld_ks[2] = '{e:1'b1, g:1'b0, huge_page:1'b0, asid:10'h13, vppn:19'h00300};
    load_store();
    repeat (2) @(negedge clk);

    check("rst_upd", upd_o, '0);
    check("rst_rsp_valid", rsp_valid_o, 1'b0);
    check("rst_rsp_hit", rsp_hit_o, 1'b0);
    check("rst_rsp_err", rsp_err_o, 1'b0);
    check("rst_rsp_idx", rsp_idx_o, '0);
    check("rst_rsp_key", rsp_key_o, '0);
    check("rst_lkp", {lkp_asid_o, lkp_vppn_o}, '0);
    check("rst_rd_idx", rd_idx_o, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_req(tbl[i].op, tbl[i].idx, tbl[i].key, tbl[i].match, tbl[i].iop, tbl[i].ia, 19'h0, lat);
      check($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      if (tbl[i].chk_hit) check($sformatf("tbl%0d_hit", i), rsp_hit_o, tbl[i].hit);
      if (tbl[i].chk_idx) check($sformatf("tbl%0d_idx", i), rsp_idx_o, tbl[i].ridx);
      if (tbl[i].chk_err) check($sformatf("tbl%0d_err", i), rsp_err_o, tbl[i].err);
      if (i == 5) begin
        check("inv4_e0", ks[0].e, 1'b0);
        check("inv4_e1", ks[1].e, 1'b1);
        check("inv4_e2", ks[2].e, 1'b1);
      end
    end

    // Two back-to-back fills straddling the counter wrap.
    for (int w = 0; w < 2 * N && tb_cnt != 29; w++) @(negedge clk);
    do_req(OP_FILL, '0, rand_key(), '0, '0, '0, '0, lat);
    check("fill_a_idx", rsp_idx_o, 5'd30);
    do_req(OP_FILL, '0, rand_key(), '0, '0, '0, '0, lat);
    check("fill_b_idx", rsp_idx_o, 5'd2);

    for (int r = 0; r < 30; r++) begin
      sel  = $urandom_range(0, 9);
      op   = (sel < 2) ? OP_SRCH : (sel < 4) ? OP_RD : (sel < 6) ? OP_WR : (sel < 8) ? OP_FILL : OP_INV;
      ridx = IW'($urandom_range(0, N - 1));
      m    = ($urandom_range(0, 1) == 1) ? N'($urandom()) : N'($urandom() & $urandom() & $urandom());
      src  = ref_ks[$urandom_range(0, N - 1)];
      iop  = 5'($urandom_range(0, 9));
      ia   = ($urandom_range(0, 1) == 1) ? src.asid : 10'($urandom());
      iv   = src.vppn ^ (($urandom_range(0, 1) == 1) ? 19'($urandom_range(0, 1023)) : 19'd0);
      do_req(op, ridx, rand_key(), m, iop, ia, iv, lat);
    end

    // Reset during an all-entries INV while entry 10 is being scanned.
    for (int i = 0; i < N; i++) begin
      ld_ks[i]   = rand_key();
      ld_ks[i].e = 1'b1;
    end
    load_store();
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = OP_INV; inv_op_i = 5'd0;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    for (int c = 1; c <= 12; c++) @(negedge clk);
    check("inv_k10_upd", upd_o, 32'h0000_0400);
    rst_n = 1'b0;
    #1;
    check("rst_mid_upd", upd_o, '0);
    check("rst_mid_rsp_valid", rsp_valid_o, 1'b0);
    for (int k = 0; k < 10; k++) ref_ks[k].e = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", req_ready_o, 1'b1);
    for (int k = 0; k < N; k++) check($sformatf("rst_mid_entry%0d", k), ks[k], ref_ks[k]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wired_tlb_mgr.md
WIRED_TLB_MGR -- requirements
Module: wired_tlb_mgr

Interface
REQ-001 SHALL have parameter TLB_ENTRIES, default 32, number of TLB entries managed; power of two, 4..64.
REQ-002 SHALL have ports, one per line; clock and reset are fixed as: one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  1  management request valid.
- req_ready_o  out  1  controller can accept a request.
- req_op_i  in  tlb_op_t  SRCH / RD / WR / FILL / INV.
- req_idx_i  in  log2(TLB_ENTRIES)  target index for RD/WR.
- req_key_i  in  tlb_key_t  key for WR/FILL; vppn/asid for SRCH.
- inv_op_i  in  5  INVTLB op code.
- inv_asid_i  in  10  INVTLB asid.
- inv_vppn_i  in  19  INVTLB vppn.
- lkp_vppn_o  out  19  vppn broadcast to all entry matchers.
- lkp_asid_o  out  10  asid broadcast to all entry matchers.
- match_i  in  TLB_ENTRIES  per-entry match from matchers.
- rd_idx_o  out  log2(TLB_ENTRIES)  key-store read index.
- rd_key_i  in  tlb_key_t  key at rd_idx_o, combinational.
- upd_o  out  TLB_ENTRIES  one-hot entry update strobe.
- upd_key_o  out  tlb_key_t  key written on upd_o.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_hit_o  out  1  SRCH hit.
- rsp_idx_o  out  log2(TLB_ENTRIES)  SRCH hit index / FILL chosen index.
- rsp_key_o  out  tlb_key_t  RD result.
- rsp_err_o  out  1  INV with illegal op code.

Function
REQ-003 SHALL accept a request on req_valid_i && req_ready_o; req_ready_o=1 only in IDLE.
REQ-004 SHALL implement states IDLE, SRCH, UPD, INV, RSP; each request resolves to RSP, then returns to IDLE.
REQ-005 SRCH: accept cycle latches vppn/asid onto lkp_*_o; SRCH state samples match_i; RSP next cycle; rsp_hit_o=|match_i, rsp_idx_o=lowest set index.
REQ-006 SRCH with multiple match bits SHALL report the lowest index, with no error.
REQ-007 RD: accept drives rd_idx_o=req_idx_i; rd_key_i registered; RSP next cycle with rsp_key_o. Total latency 2 cycles.
REQ-008 WR: UPD state asserts upd_o[req_idx_i] for exactly one cycle with upd_key_o=req_key_i; RSP follows.
REQ-009 FILL: same as WR, with index = free-running counter value at accept; rsp_idx_o reports it.
REQ-010 The fill counter SHALL increment every cycle and wrap TLB_ENTRIES-1 -> 0.
REQ-011 INV: scans entry k=0..TLB_ENTRIES-1, one per cycle, via rd_idx_o=k; if rd_key_i.e and the predicate holds, assert upd_o[k] with rd_key_i but e=0.
REQ-012 INV predicates:
- op 0/1: all entries.
- op 2: g=1.
- op 3: g=0.
- op 4: g=0 && asid match.
- op 5: g=0 && asid match && vppn match.
- op 6: (g=1 || asid match) && vppn match.
- vppn match SHALL honour huge_page (compare [18:10] only).
REQ-013 INV with op >6 SHALL go straight to RSP with rsp_err_o=1 and no upd_o.
REQ-014 INV latency SHALL be TLB_ENTRIES+2 cycles, accept to rsp_valid_o.
REQ-015 upd_o SHALL be zero outside UPD/INV, and at most one bit set in any cycle.
REQ-016 rsp_* other than rsp_valid_o SHALL hold their value until the next RSP.
REQ-017 req_valid_i while not ready SHALL be ignored; the requester holds its request.

Reset
REQ-018 During reset: state=IDLE, fill counter=0, upd_o=0, rsp_valid_o=0, rsp_hit_o=0, rsp_err_o=0, rsp_idx_o=0, rsp_key_o=0, lkp_*_o=0, rd_idx_o=0.
REQ-019 Reset mid-operation SHALL abort the operation with no further upd_o; entries not yet scanned by INV remain unmodified.

Structure
REQ-020 tlb_op_t, tlb_key_t and the INV op code constants SHALL live in the shared wired0 package.
REQ-021 The lowest-index priority encoder SHALL be sub-module wired_tlb_prio_enc.

Verification
REQ-022 SRCH with match_i=32'h0000_0050 -> rsp_valid_o 2 cycles after accept, rsp_hit_o=1, rsp_idx_o=4.
REQ-023 WR idx 7 -> upd_o=1<<7 for one cycle with upd_key_o=req_key_i, rsp_valid_o next cycle.
REQ-024 INV op 4 asid 0x12 over entries {0: g=0,asid=0x12; 1: g=1,asid=0x12; 2: g=0,asid=0x13} -> only upd_o[0] fires, e=0; rsp at cycle 34.
REQ-025 INV op 9 -> rsp_err_o=1 in 2 cycles, upd_o stays 0.
REQ-026 Two back-to-back FILLs -> distinct rsp_idx_o values, counter wraps 31 -> 0.
REQ-027 rst_n low during INV at k=10 -> upd_o=0 immediately, req_ready_o=1 after release, entries 10..31 unchanged.
